score_keeper: RTL and testbench

//  Parametrised BCD score accumulator; next generation of the per-digit up-counter score chain.

---
 rtl/score_keeper.sv | 173 +++++++++++++++++
 tb/tb_score_keeper.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: weighted event scoring into a BCD score through a serial digit adder.
// Define SCORE_HISCORE_EN to add the high-score register and game-over compare.
module score_keeper #(
  parameter int unsigned DIGIT_AMOUNT = 3,
  parameter int unsigned MONSTER_PTS  = 1,
  parameter int unsigned BOSS_PTS     = 5,
  parameter int unsigned ASTEROID_PTS = 2,
  parameter int unsigned PEND_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      monster_died_pulse,
  input  logic                      boss_died_pulse,
  input  logic                      asteroid_exploded_pulse,
  input  logic [2:0]                stage_num,
  input  logic                      game_over,
  input  logic                      clear_score,
  output logic [4*DIGIT_AMOUNT-1:0] score_bcd,
  output logic [4*DIGIT_AMOUNT-1:0] hi_score_bcd,
  output logic [7*DIGIT_AMOUNT-1:0] ss,
  output logic                      busy,
  output logic                      saturated,
  output logic                      new_record
);

  localparam int unsigned IW = (DIGIT_AMOUNT > 1) ? $clog2(DIGIT_AMOUNT) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(DIGIT_AMOUNT - 1);
  localparam logic [32:0] PendMax = (33'd1 << PEND_W) - 33'd1;
  localparam logic [4*DIGIT_AMOUNT-1:0] AllNines = {DIGIT_AMOUNT{4'h9}};

  typedef enum logic [1:0] {StIdle, StAdd, StCmp, StDone} state_e;

  state_e                    state_q;
  logic [PEND_W-1:0]         pending_q, pending_d, take;
  logic [4*DIGIT_AMOUNT-1:0] score_q;
  logic [3:0]                chunk_q;
  logic [IW-1:0]             idx_q;
  logic                      carry_q, sat_q, new_record_q;
  logic                      start_chunk;
  logic [31:0]               ev_pts, add_w;
  logic [32:0]               sum_w;
  logic [3:0]                cur_dig, dig_nxt;
  logic [4:0]                dig_sum;
  logic                      dig_carry;
`ifdef SCORE_HISCORE_EN
  logic [4*DIGIT_AMOUNT-1:0] hi_q;
  logic [3:0]                hi_dig;
`endif

  // Seven-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hexss(input logic [3:0] d);
    unique case (d)
      4'h0: hexss = 7'h3F;  4'h1: hexss = 7'h06;  4'h2: hexss = 7'h5B;  4'h3: hexss = 7'h4F;
      4'h4: hexss = 7'h66;  4'h5: hexss = 7'h6D;  4'h6: hexss = 7'h7D;  4'h7: hexss = 7'h07;
      4'h8: hexss = 7'h7F;  4'h9: hexss = 7'h6F;  4'hA: hexss = 7'h77;  4'hB: hexss = 7'h7C;
      4'hC: hexss = 7'h39;  4'hD: hexss = 7'h5E;  4'hE: hexss = 7'h79;  default: hexss = 7'h71;
    endcase
  endfunction

  always_comb begin
    ev_pts = (monster_died_pulse      ? 32'(MONSTER_PTS)  : 32'd0)
           + (boss_died_pulse         ? 32'(BOSS_PTS)     : 32'd0)
           + (asteroid_exploded_pulse ? 32'(ASTEROID_PTS) : 32'd0);
    add_w  = (!game_over && !clear_score) ? 32'(stage_num) * ev_pts : 32'd0;

    start_chunk = (state_q == StIdle) && (pending_q != '0) && !sat_q && !clear_score;
    take = '0;
    if (start_chunk) take = (32'(pending_q) > 32'd9) ? PEND_W'(9) : pending_q;

    sum_w = 33'(pending_q) - 33'(take) + 33'(add_w);
    if (clear_score || sat_q) pending_d = '0;
    else if (sum_w > PendMax) pending_d = PendMax[PEND_W-1:0];
    else                      pending_d = sum_w[PEND_W-1:0];
  end

  always_comb begin
    cur_dig   = score_q[{idx_q, 2'b00} +: 4];
    dig_sum   = 5'(cur_dig) + 5'(carry_q) + ((idx_q == '0) ? 5'(chunk_q) : 5'd0);
    dig_carry = dig_sum > 5'd9;
    dig_nxt   = dig_carry ? 4'(dig_sum - 5'd10) : dig_sum[3:0];
`ifdef SCORE_HISCORE_EN
    hi_dig    = hi_q[{idx_q, 2'b00} +: 4];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      score_q      <= '0;
      chunk_q      <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      sat_q        <= 1'b0;
      new_record_q <= 1'b0;
`ifdef SCORE_HISCORE_EN
      hi_q         <= '0;
`endif
    end else begin
      pending_q    <= pending_d;
      new_record_q <= 1'b0;
      if (clear_score) begin
        state_q <= StIdle;
        score_q <= '0;
        sat_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_chunk) begin
              chunk_q <= take[3:0];
              idx_q   <= '0;
              carry_q <= 1'b0;
              state_q <= StAdd;
            end else if (pending_q == '0 && game_over) begin
`ifdef SCORE_HISCORE_EN
              idx_q   <= LastIdx;
              state_q <= StCmp;
`else
              state_q <= StDone;
`endif
            end
          end
          StAdd: begin
            score_q[{idx_q, 2'b00} +: 4] <= dig_nxt;
            carry_q <= dig_carry;
            if (idx_q == LastIdx) begin
              state_q <= StIdle;
              // Carry out of the MSD: clamp the whole score instead of wrapping.
              if (dig_carry) begin
                score_q <= AllNines;
                sat_q   <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          StCmp: begin
`ifdef SCORE_HISCORE_EN
            if (cur_dig > hi_dig) begin
              hi_q         <= score_q;
              new_record_q <= 1'b1;
              state_q      <= StDone;
            end else if (cur_dig < hi_dig || idx_q == '0) begin
              state_q <= StDone;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
`else
            state_q <= StDone;
`endif
          end
          StDone: if (!game_over) state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DIGIT_AMOUNT); i++) ss[7*i +: 7] = hexss(score_q[4*i +: 4]);
  end

  assign score_bcd  = score_q;
  assign saturated  = sat_q;
  assign new_record = new_record_q;
  assign busy       = (pending_q != '0) || (state_q == StAdd) || (state_q == StCmp);
`ifdef SCORE_HISCORE_EN
  assign hi_score_bcd = hi_q;
`else
  assign hi_score_bcd = '0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper: vector table with an expected-result queue plus
// hand-written sequences for latency, pending clamp, high score and clear.
module tb_score_keeper;
`ifdef SCORE_HISCORE_EN
  localparam bit HiEn = 1'b1;
`else
  localparam bit HiEn = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        m = 1'b0, b = 1'b0, a = 1'b0, game_over = 1'b0, clear_score = 1'b0;
  logic [2:0]  stage_num = 3'd0;
  logic [11:0] score_bcd, hi_score_bcd;
  logic [20:0] ss;
  logic        busy, saturated, new_record;

  int checks = 0, errors = 0, nr_cnt = 0, nr0;

  always #5 clk = ~clk;
  always @(negedge clk) if (new_record) nr_cnt++;

  score_keeper dut (
    .clk                     (clk),
    .reset                   (reset),
    .monster_died_pulse      (m),
    .boss_died_pulse         (b),
    .asteroid_exploded_pulse (a),
    .stage_num               (stage_num),
    .game_over               (game_over),
    .clear_score             (clear_score),
    .score_bcd               (score_bcd),
    .hi_score_bcd            (hi_score_bcd),
    .ss                      (ss),
    .busy                    (busy),
    .saturated               (saturated),
    .new_record              (new_record)
  );

  typedef struct {
    bit          clr;
    logic [2:0]  stage;
    bit          pm, pb, pa;
    int          reps;
    logic [11:0] score;
    bit          sat;
  } vec_t;

  typedef struct {
    logic [11:0] score;
    bit          sat;
  } exp_t;

  vec_t vecs[13];
  exp_t exp_q[$];
  exp_t e;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h3F; 4'd1: seg = 7'h06; 4'd2: seg = 7'h5B; 4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66; 4'd5: seg = 7'h6D; 4'd6: seg = 7'h7D; 4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F; 4'd9: seg = 7'h6F; default: seg = 7'h00;
    endcase
  endfunction

  function automatic logic [20:0] exp_ss(input logic [11:0] s);
    logic [20:0] r;
    for (int i = 0; i < 3; i++) r[7*i +: 7] = seg(s[4*i +: 4]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk); clear_score = 1'b1;
    @(negedge clk); clear_score = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] st, input bit pm, input bit pb, input bit pa);
    @(negedge clk); stage_num = st; m = pm; b = pb; a = pa;
    @(negedge clk); m = 1'b0; b = 1'b0; a = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still %0b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  initial begin
    //           clr stage m  b  a  reps score   sat
    vecs[0]  = '{1, 3'd1, 1, 0, 0, 1,  12'h001, 0};
    vecs[1]  = '{0, 3'd1, 0, 1, 1, 1,  12'h008, 0};
    vecs[2]  = '{0, 3'd1, 1, 0, 0, 1,  12'h009, 0};
    vecs[3]  = '{0, 3'd2, 1, 0, 0, 1,  12'h011, 0};
    vecs[4]  = '{1, 3'd3, 1, 1, 1, 1,  12'h024, 0};
    vecs[5]  = '{0, 3'd7, 0, 1, 0, 1,  12'h059, 0};
    vecs[6]  = '{0, 3'd0, 1, 1, 1, 1,  12'h059, 0};
    vecs[7]  = '{0, 3'd7, 1, 1, 1, 1,  12'h115, 0};
    vecs[8]  = '{0, 3'd7, 0, 1, 1, 18, 12'h997, 0};
    vecs[9]  = '{0, 3'd1, 1, 0, 0, 1,  12'h998, 0};
    vecs[10] = '{0, 3'd1, 0, 1, 0, 1,  12'h999, 1};
    vecs[11] = '{0, 3'd1, 1, 0, 0, 1,  12'h999, 1};
    vecs[12] = '{1, 3'd1, 0, 0, 1, 1,  12'h002, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_score", 32'(score_bcd), 32'h0);
    check("rst_hi", 32'(hi_score_bcd), 32'h0);
    check("rst_ss", 32'(ss), 32'(exp_ss(12'h000)));
    check("rst_flags", {29'd0, busy, saturated, new_record}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single chunk latency: busy for exactly four cycles
    stage_num = 3'd1; m = 1'b1;
    @(negedge clk); m = 1'b0;
    check("lat_busy0", 32'(busy), 32'h1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("lat_busy%0d", k), 32'(busy), 32'h1);
    end
    @(negedge clk);
    check("lat_busy_end", 32'(busy), 32'h0);
    check("lat_score", 32'(score_bcd), 32'h001);

    // Vector table through the expected-result queue
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].clr) do_clear();
      exp_q.push_back('{vecs[i].score, vecs[i].sat});
      for (int r = 0; r < vecs[i].reps; r++) begin
        pulse(vecs[i].stage, vecs[i].pm, vecs[i].pb, vecs[i].pa);
        wait_idle($sformatf("vec%0d_idle", i));
      end
      e = exp_q.pop_front();
      check($sformatf("vec%0d_score", i), 32'(score_bcd), 32'(e.score));
      check($sformatf("vec%0d_sat", i), 32'(saturated), 32'(e.sat));
      check($sformatf("vec%0d_ss", i), 32'(ss), 32'(exp_ss(e.score)));
    end

    // Pending clamps at 255: five back-to-back 56-point events yield 9 + 255
    do_clear();
    @(negedge clk); stage_num = 3'd7; m = 1'b1; b = 1'b1; a = 1'b1;
    repeat (5) @(negedge clk);
    m = 1'b0; b = 1'b0; a = 1'b0;
    wait_idle("pclamp_idle");
    check("pclamp_score", 32'(score_bcd), 32'h264);
    check("pclamp_sat", 32'(saturated), 32'h0);

    // High score: 010 over 000, then 024 over 010, then equal 024
    do_clear();
    pulse(3'd2, 0, 1, 0);
    wait_idle("hi1_idle");
    check("hi1_score", 32'(score_bcd), 32'h010);
    nr0 = nr_cnt;
    @(negedge clk); game_over = 1'b1;
    repeat (8) @(negedge clk);
    check("hi1_hi", 32'(hi_score_bcd), HiEn ? 32'h010 : 32'h0);
    check("hi1_pulses", 32'(nr_cnt - nr0), HiEn ? 32'd1 : 32'd0);
    pulse(3'd1, 1, 0, 0);
    repeat (4) @(negedge clk);
    check("gameover_ignores_pulse", 32'(score_bcd), 32'h010);
    game_over = 1'b0;
    @(negedge clk);

    do_clear();
    pulse(3'd3, 1, 1, 1);
    wait_idle("hi2_idle");
    nr0 = nr_cnt;
    @(negedge clk); game_over = 1'b1;
    repeat (8) @(negedge clk);
    check("hi2_hi", 32'(hi_score_bcd), HiEn ? 32'h024 : 32'h0);
    check("hi2_pulses", 32'(nr_cnt - nr0), HiEn ? 32'd1 : 32'd0);
    game_over = 1'b0;
    @(negedge clk);

    do_clear();
    pulse(3'd3, 1, 1, 1);
    wait_idle("hi3_idle");
    nr0 = nr_cnt;
    @(negedge clk); game_over = 1'b1;
    repeat (8) @(negedge clk);
    check("hi3_hi", 32'(hi_score_bcd), HiEn ? 32'h024 : 32'h0);
    check("hi3_no_pulse", 32'(nr_cnt - nr0), 32'd0);
    game_over = 1'b0;
    @(negedge clk);

    // Clear wins over a same-cycle monster pulse while busy
    pulse(3'd1, 0, 1, 0);
    check("clr_busy_before", 32'(busy), 32'h1);
    clear_score = 1'b1; m = 1'b1; stage_num = 3'd1;
    @(negedge clk); clear_score = 1'b0; m = 1'b0;
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_score", 32'(score_bcd), 32'h000);
    repeat (6) @(negedge clk);
    check("clr_score_hold", 32'(score_bcd), 32'h000);
    check("clr_hi_kept", 32'(hi_score_bcd), HiEn ? 32'h024 : 32'h0);
    check("clr_sat", 32'(saturated), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
